// File: rtl/stepper_move_sequencer_if.sv
// Move-command handshake between the UI command logic and the stepper sequencer.
interface stepper_move_sequencer_if #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned STEPS_W  = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [STEPS_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_move_sequencer.sv
// Runs one queued move at a time on a 4-coil unipolar stepper, with a linear period ramp
// for acceleration and deceleration, and tracks the signed absolute position.
module stepper_move_sequencer #(
  parameter int unsigned         PERIOD_W     = 24,
  parameter int unsigned         STEPS_W      = 16,
  parameter int unsigned         POS_W        = 32,
  parameter logic [PERIOD_W-1:0] START_PERIOD = 24'd270000,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD   = 24'd27000,
  parameter logic [PERIOD_W-1:0] RAMP_DEC     = 24'd13500,
  parameter bit                  HALF_STEP    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  stepper_move_sequencer_if.slave cmd,
  input  logic                    abort,
  input  logic                    coil_hold,
  output logic                    in1,
  output logic                    in2,
  output logic                    in3,
  output logic                    in4,
  output logic                    step_pulse,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position
);

  typedef enum logic [2:0] {StIdle, StRampUp, StCruise, StRampDown, StDone} state_e;

  localparam logic [2:0] IdxMask = HALF_STEP ? 3'd7 : 3'd3;

  state_e              state_q;
  logic [PERIOD_W-1:0] tick_q, cur_q, tgt_q;
  logic [STEPS_W-1:0]  rem_q, ramp_q;
  logic                dir_q, aborted_q;
  logic [2:0]          idx_q;
  logic [3:0]          coils_q;
  logic signed [POS_W-1:0] pos_q;

  logic                moving, step;
  logic [STEPS_W-1:0]  rem_nx, ramp_nx;
  logic [2:0]          idx_nx;
  logic [PERIOD_W-1:0] cur_up, cur_dn, cmd_tgt;

  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    logic [3:0] p;
    p = 4'b0000;
    if (HALF_STEP) begin
      case (idx)
        3'd0: p = 4'b1000;
        3'd1: p = 4'b1100;
        3'd2: p = 4'b0100;
        3'd3: p = 4'b0110;
        3'd4: p = 4'b0010;
        3'd5: p = 4'b0011;
        3'd6: p = 4'b0001;
        default: p = 4'b1001;
      endcase
    end else begin
      case (idx[1:0])
        2'd0: p = 4'b1100;
        2'd1: p = 4'b0110;
        2'd2: p = 4'b0011;
        default: p = 4'b1001;
      endcase
    end
    return p;
  endfunction

  always_comb begin
    moving  = (state_q == StRampUp) || (state_q == StCruise) || (state_q == StRampDown);
    // Abort wins over a step due in the same cycle.
    step    = moving && (tick_q == cur_q - PERIOD_W'(1)) && !abort;
    rem_nx  = rem_q - STEPS_W'(1);
    ramp_nx = (state_q == StRampUp && ramp_q != '1) ? ramp_q + STEPS_W'(1) : ramp_q;
    idx_nx  = (dir_q ? idx_q + 3'd1 : idx_q - 3'd1) & IdxMask;
    // Differences are compared first so neither direction can wrap.
    cur_up  = (START_PERIOD - cur_q > RAMP_DEC) ? cur_q + RAMP_DEC : START_PERIOD;
    cur_dn  = (cur_q - tgt_q > RAMP_DEC) ? cur_q - RAMP_DEC : tgt_q;
    if (cmd.cmd_period < MIN_PERIOD)        cmd_tgt = MIN_PERIOD;
    else if (cmd.cmd_period > START_PERIOD) cmd_tgt = START_PERIOD;
    else                                    cmd_tgt = cmd.cmd_period;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      cur_q     <= START_PERIOD;
      tgt_q     <= START_PERIOD;
      rem_q     <= '0;
      ramp_q    <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      idx_q     <= 3'd0;
      coils_q   <= 4'b0000;
      pos_q     <= '0;
    end else begin
      coils_q <= (state_q == StIdle && !coil_hold) ? 4'b0000 : coil_pattern(idx_q);
      unique case (state_q)
        StIdle: begin
          if (cmd.cmd_valid) begin
            dir_q     <= cmd.cmd_dir;
            rem_q     <= cmd.cmd_steps;
            tgt_q     <= cmd_tgt;
            cur_q     <= START_PERIOD;
            ramp_q    <= '0;
            tick_q    <= '0;
            aborted_q <= 1'b0;
            if (cmd.cmd_steps == '0)         state_q <= StDone;
            else if (cmd_tgt == START_PERIOD) state_q <= StCruise;
            else                              state_q <= StRampUp;
          end
        end
        StDone: state_q <= StIdle;
        default: begin
          if (abort) begin
            state_q   <= StDone;
            aborted_q <= 1'b1;
          end else if (step) begin
            tick_q <= '0;
            idx_q  <= idx_nx;
            pos_q  <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            rem_q  <= rem_nx;
            ramp_q <= ramp_nx;
            if (rem_nx == '0) begin
              state_q <= StDone;
            end else if (rem_nx <= ramp_nx) begin
              cur_q   <= cur_up;
              state_q <= StRampDown;
            end else if (state_q == StRampUp) begin
              cur_q <= cur_dn;
              if (cur_dn == tgt_q) state_q <= StCruise;
            end
          end else begin
            tick_q <= tick_q + PERIOD_W'(1);
          end
        end
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign aborted       = done && aborted_q;
  assign step_pulse    = step;
  assign position      = pos_q;
  assign {in1, in2, in3, in4} = coils_q;

endmodule
